fetch_stage: RTL and testbench



---
 rtl/fetch_stage.sv | 90 +++++++++
 tb/tb_fetch_stage.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage sitting in front of the instruction
// memory. Owns the PC, drives the memory address, and registers the returned
// word together with its PC into the IF/ID register read by decode.
//
// Ports:
//   clk, rst        clock (rising edge), asynchronous active-low reset
//   imem_addr       byte address to instruction memory (== pc_f)
//   imem_rd         combinational read data for imem_addr
//   stall_f         hold PC
//   stall_d         hold IF/ID register
//   flush_d         replace IF/ID contents with a NOP bubble
//   pc_src_e        execute-stage redirect request
//   pc_target_e     redirect target byte address (low bits dropped)
//   pc_f            current fetch PC
//   instr_d, pc_d, pc_plus4_d, valid_d   IF/ID register outputs
//   misalign_f      one-cycle pulse when a redirect target was not word aligned
//   instr_count     running count of valid instructions handed to decode
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
  parameter int          CNT_W     = 32
) (
  input  logic             clk,
  input  logic             rst,
  output logic [31:0]      imem_addr,
  input  logic [31:0]      imem_rd,
  input  logic             stall_f,
  input  logic             stall_d,
  input  logic             flush_d,
  input  logic             pc_src_e,
  input  logic [31:0]      pc_target_e,
  output logic [31:0]      pc_f,
  output logic [31:0]      instr_d,
  output logic [31:0]      pc_d,
  output logic [31:0]      pc_plus4_d,
  output logic             valid_d,
  output logic             misalign_f,
  output logic [CNT_W-1:0] instr_count
);

  logic [31:0] pc_plus4_f;
  logic [31:0] pc_next;
  logic        ifid_load;

  assign imem_addr  = pc_f;
  assign pc_plus4_f = pc_f + 32'd4;  // modular: 0xFFFFFFFC wraps to 0
  assign ifid_load  = !flush_d && !stall_d;

  // Redirect wins over stall: a taken branch must not be lost while the
  // hazard unit is holding fetch.
  always_comb begin
    pc_next = pc_plus4_f;
    if (pc_src_e)     pc_next = {pc_target_e[31:2], 2'b00};
    else if (stall_f) pc_next = pc_f;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_f       <= RESET_PC;
      misalign_f <= 1'b0;
    end else begin
      pc_f       <= pc_next;
      misalign_f <= pc_src_e && (pc_target_e[1:0] != 2'b00);
    end
  end

  // IF/ID register. Flush beats stall so a squashed wrong-path word can never
  // be held in decode.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      instr_d     <= NOP_INSTR;
      pc_d        <= 32'h0;
      pc_plus4_d  <= 32'h0;
      valid_d     <= 1'b0;
      instr_count <= '0;
    end else if (flush_d) begin
      instr_d    <= NOP_INSTR;
      pc_d       <= 32'h0;
      pc_plus4_d <= 32'h0;
      valid_d    <= 1'b0;
    end else if (ifid_load) begin
      instr_d     <= imem_rd;
      pc_d        <= pc_f;
      pc_plus4_d  <= pc_plus4_f;
      valid_d     <= 1'b1;
      instr_count <= instr_count + CNT_W'(1);  // wraps, no saturation
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

  logic        clk, rst;
  logic [31:0] imem_addr, imem_rd, pc_target_e, pc_f, instr_d, pc_d, pc_plus4_d;
  logic        stall_f, stall_d, flush_d, pc_src_e, valid_d, misalign_f;
  logic [31:0] instr_count;
  // narrow-counter instance used only to see the count wrap
  logic [31:0] s_addr, s_pc_f, s_instr_d, s_pc_d, s_pc_plus4_d;
  logic        s_valid_d, s_misalign_f;
  logic [2:0]  s_count;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } exp_t;
  exp_t sbq[$];

  int nvec = 0;
  int nerr = 0;

  logic [31:0] mem [0:63];
  logic [31:0] iw  [0:5];

  // memory returns 0 while reset is held
  assign imem_rd = rst ? mem[imem_addr[7:2]] : 32'h0;

  fetch_stage dut (
    .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_rd(imem_rd),
    .stall_f(stall_f), .stall_d(stall_d), .flush_d(flush_d),
    .pc_src_e(pc_src_e), .pc_target_e(pc_target_e), .pc_f(pc_f),
    .instr_d(instr_d), .pc_d(pc_d), .pc_plus4_d(pc_plus4_d),
    .valid_d(valid_d), .misalign_f(misalign_f), .instr_count(instr_count)
  );

  fetch_stage #(.CNT_W(3)) dut_s (
    .clk(clk), .rst(rst), .imem_addr(s_addr), .imem_rd(imem_rd),
    .stall_f(stall_f), .stall_d(stall_d), .flush_d(flush_d),
    .pc_src_e(pc_src_e), .pc_target_e(pc_target_e), .pc_f(s_pc_f),
    .instr_d(s_instr_d), .pc_d(s_pc_d), .pc_plus4_d(s_pc_plus4_d),
    .valid_d(s_valid_d), .misalign_f(s_misalign_f), .instr_count(s_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rst = 1'b0; stall_f = 0; stall_d = 0; flush_d = 0; pc_src_e = 0;
    pc_target_e = 32'h0;
    sbq.delete();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    reset_dut();
    rst = 1'b0;
    #1;
    nvec++;
    if ({pc_f, instr_d, pc_d, pc_plus4_d, valid_d, misalign_f, instr_count, imem_addr} !==
        {32'h0, 32'h13, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0}) begin
      nerr++;
      $display("FAIL reset_state: got pc=%h ins=%h pcd=%h p4=%h v=%b m=%b cnt=%0d",
               pc_f, instr_d, pc_d, pc_plus4_d, valid_d, misalign_f, instr_count);
    end
  endtask

  task automatic test_sequential();
    exp_t e;
    reset_dut();
    for (int k = 0; k < 6; k++) sbq.push_back('{instr: iw[k], pc: 32'(k * 4)});
    for (int k = 0; k < 6; k++) begin
      tick();
      e = sbq.pop_front();
      nvec++;
      if ({instr_d, pc_d, pc_plus4_d, valid_d} !== {e.instr, e.pc, e.pc + 32'd4, 1'b1}) begin
        nerr++;
        $display("FAIL seq_load%0d: got ins=%h pc=%h p4=%h v=%b want ins=%h pc=%h",
                 k, instr_d, pc_d, pc_plus4_d, valid_d, e.instr, e.pc);
      end
      if (k == 0) begin
        nvec++;
        if (imem_addr !== 32'h4) begin
          nerr++;
          $display("FAIL seq_imem_addr: got %h want 00000004", imem_addr);
        end
      end
    end
    nvec++;
    if (instr_count !== 32'd6) begin
      nerr++;
      $display("FAIL seq_count: got %0d want 6", instr_count);
    end
    tick(); tick();
    nvec++;
    if (instr_count !== 32'd8 || s_count !== 3'd0) begin
      nerr++;
      $display("FAIL count_wrap: got %0d/%0d want 8/0", instr_count, s_count);
    end
  endtask

  task automatic test_stall();
    exp_t e;
    reset_dut();
    tick(); tick();
    stall_f = 1; stall_d = 1;
    tick(); tick();
    nvec++;
    if (pc_f !== 32'h8 || instr_d !== 32'h00B67433 || instr_count !== 32'd2) begin
      nerr++;
      $display("FAIL stall_hold: got pc=%h ins=%h cnt=%0d want 8/00b67433/2",
               pc_f, instr_d, instr_count);
    end
    stall_f = 0; stall_d = 0;
    sbq.push_back('{instr: iw[2], pc: 32'h8});
    tick();
    e = sbq.pop_front();
    nvec++;
    if (instr_d !== e.instr || pc_d !== e.pc || instr_count !== 32'd3) begin
      nerr++;
      $display("FAIL stall_release: got ins=%h pc=%h cnt=%0d want ins=%h pc=%h cnt=3",
               instr_d, pc_d, instr_count, e.instr, e.pc);
    end
    // fetch stalled, decode not: same word reloaded, counted each time
    stall_f = 1;
    for (int k = 0; k < 2; k++) sbq.push_back('{instr: iw[3], pc: 32'hC});
    for (int k = 0; k < 2; k++) begin
      tick();
      e = sbq.pop_front();
      nvec++;
      if ({instr_d, pc_d, valid_d, instr_count} !== {e.instr, e.pc, 1'b1, 32'(4 + k)}) begin
        nerr++;
        $display("FAIL stallf_reload%0d: got ins=%h pc=%h v=%b cnt=%0d want ins=%h cnt=%0d",
                 k, instr_d, pc_d, valid_d, instr_count, e.instr, 4 + k);
      end
    end
    stall_f = 0;
  endtask

  task automatic test_redirect_flush();
    exp_t e;
    reset_dut();
    tick(); tick();
    pc_src_e = 1; pc_target_e = 32'h14; flush_d = 1;
    tick();
    pc_src_e = 0; flush_d = 0;
    nvec++;
    if ({pc_f, instr_d, pc_d, valid_d, misalign_f, instr_count} !==
        {32'h14, 32'h13, 32'h0, 1'b0, 1'b0, 32'd2}) begin
      nerr++;
      $display("FAIL redirect_flush: got pc=%h ins=%h pcd=%h v=%b m=%b cnt=%0d",
               pc_f, instr_d, pc_d, valid_d, misalign_f, instr_count);
    end
    sbq.push_back('{instr: iw[5], pc: 32'h14});
    tick();
    e = sbq.pop_front();
    nvec++;
    if ({instr_d, pc_d, pc_plus4_d, valid_d} !== {e.instr, e.pc, e.pc + 32'd4, 1'b1}) begin
      nerr++;
      $display("FAIL redirect_target: got ins=%h pc=%h p4=%h v=%b want ins=%h pc=%h",
               instr_d, pc_d, pc_plus4_d, valid_d, e.instr, e.pc);
    end
    // flush must beat stall_d
    flush_d = 1; stall_d = 1;
    tick();
    flush_d = 0; stall_d = 0;
    nvec++;
    if (valid_d !== 1'b0 || instr_d !== 32'h13) begin
      nerr++;
      $display("FAIL flush_over_stall: got v=%b ins=%h want 0/00000013", valid_d, instr_d);
    end
  endtask

  task automatic test_misalign();
    exp_t e;
    reset_dut();
    tick();
    pc_src_e = 1; pc_target_e = 32'h0000_000E;
    tick();
    pc_src_e = 0;
    nvec++;
    if (pc_f !== 32'hC || misalign_f !== 1'b1) begin
      nerr++;
      $display("FAIL misalign_pulse: got pc=%h m=%b want 0000000c/1", pc_f, misalign_f);
    end
    sbq.push_back('{instr: iw[3], pc: 32'hC});
    tick();
    e = sbq.pop_front();
    nvec++;
    if (misalign_f !== 1'b0 || instr_d !== e.instr || pc_d !== e.pc) begin
      nerr++;
      $display("FAIL misalign_after: got m=%b ins=%h pc=%h want 0 ins=%h pc=%h",
               misalign_f, instr_d, pc_d, e.instr, e.pc);
    end
  endtask

  task automatic test_wrap();
    exp_t e;
    reset_dut();
    tick();
    pc_src_e = 1; pc_target_e = 32'hFFFF_FFFC; flush_d = 1;
    tick();
    pc_src_e = 0; flush_d = 0;
    nvec++;
    if (pc_f !== 32'hFFFF_FFFC) begin
      nerr++;
      $display("FAIL wrap_target: got %h want fffffffc", pc_f);
    end
    sbq.push_back('{instr: 32'hDEAD_BEE3, pc: 32'hFFFF_FFFC});
    sbq.push_back('{instr: iw[0], pc: 32'h0});
    tick();
    e = sbq.pop_front();
    nvec++;
    if ({pc_f, instr_d, pc_d, pc_plus4_d} !== {32'h0, e.instr, e.pc, 32'h0}) begin
      nerr++;
      $display("FAIL wrap_top: got pc=%h ins=%h pcd=%h p4=%h want 0 %h %h 0",
               pc_f, instr_d, pc_d, pc_plus4_d, e.instr, e.pc);
    end
    tick();
    e = sbq.pop_front();
    nvec++;
    if (instr_d !== e.instr || pc_d !== e.pc || pc_plus4_d !== 32'h4) begin
      nerr++;
      $display("FAIL wrap_next: got ins=%h pc=%h p4=%h want %h %h 4",
               instr_d, pc_d, pc_plus4_d, e.instr, e.pc);
    end
  endtask

  task automatic test_async_reset();
    exp_t e;
    reset_dut();
    tick(); tick(); tick();
    pc_src_e = 1; pc_target_e = 32'h0000_0022;
    #3 rst = 1'b0;
    #1;
    nvec++;
    if ({pc_f, instr_d, pc_d, pc_plus4_d, valid_d, misalign_f, instr_count} !==
        {32'h0, 32'h13, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0}) begin
      nerr++;
      $display("FAIL async_reset: got pc=%h ins=%h pcd=%h p4=%h v=%b m=%b cnt=%0d",
               pc_f, instr_d, pc_d, pc_plus4_d, valid_d, misalign_f, instr_count);
    end
    pc_src_e = 0; pc_target_e = 32'h0;
    @(negedge clk);
    rst = 1'b1;
    sbq.push_back('{instr: iw[0], pc: 32'h0});
    tick();
    e = sbq.pop_front();
    nvec++;
    if ({instr_d, pc_d, valid_d, misalign_f, instr_count, pc_f} !==
        {e.instr, e.pc, 1'b1, 1'b0, 32'd1, 32'h4}) begin
      nerr++;
      $display("FAIL reset_release: got ins=%h pcd=%h v=%b m=%b cnt=%0d pc=%h",
               instr_d, pc_d, valid_d, misalign_f, instr_count, pc_f);
    end
  endtask

  initial begin
    iw[0] = 32'h0062E233; iw[1] = 32'h00B67433; iw[2] = 32'h00B60933;
    iw[3] = 32'h41390433; iw[4] = 32'h015A4433; iw[5] = 32'h017B2433;
    for (int i = 0; i < 64; i++) mem[i] = 32'h1000_0000 + 32'(i);
    for (int i = 0; i < 6; i++) mem[i] = iw[i];
    mem[63] = 32'hDEAD_BEE3;
    test_reset();
    test_sequential();
    test_stall();
    test_redirect_flush();
    test_misalign();
    test_wrap();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
